seg7_capture: RTL and testbench



---
 rtl/seg7_capture.sv | 121 ++++++++++++
 tb/tb_seg7_capture.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Receive-side 7-segment capture: synchronizes an active-low segment bus, waits
// for the pattern to hold steady, and reports each new stable pattern once.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg,
   output logic [3:0] digit,
   output logic       digit_valid,
   output logic       pat_err,
   output logic       blank
);

   typedef enum logic [1:0] {IDLE, SETTLE, REPORT} state_t;

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [6:0] PAT_BLANK = 7'h7F;

   state_t     r_state;
   logic [6:0] r_sync1, r_sync2;
   logic [6:0] r_cand, r_last_pat;
   logic [7:0] r_cnt;
   logic [3:0] r_digit;
   logic       r_dv, r_err, r_blank;

   logic [6:0] w_on;
   logic       w_hit;
   logic [3:0] w_val;

   // Lookup is done on the candidate in active-high abcdefg form.
   always_comb begin
      w_on  = ~r_cand;
      w_hit = 1'b1;
      w_val = 4'h0;
      case (w_on)
         7'b1111110: w_val = 4'h0;
         7'b0110000: w_val = 4'h1;
         7'b1101101: w_val = 4'h2;
         7'b1111001: w_val = 4'h3;
         7'b0110011: w_val = 4'h4;
         7'b1011011: w_val = 4'h5;
         7'b1011111: w_val = 4'h6;
         7'b1110000: w_val = 4'h7;
         7'b1111111: w_val = 4'h8;
         7'b1111011: w_val = 4'h9;
         7'b1110111: w_val = 4'hA;
         7'b0011111: w_val = 4'hB;
         7'b1001110: w_val = 4'hC;
         7'b0111101: w_val = 4'hD;
         7'b1001111: w_val = 4'hE;
         7'b1000111: w_val = 4'hF;
         default:    w_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_sync1    <= PAT_BLANK;
         r_sync2    <= PAT_BLANK;
         r_cand     <= PAT_BLANK;
         r_last_pat <= PAT_BLANK;
         r_cnt      <= 8'd0;
         r_digit    <= 4'h0;
         r_dv       <= 1'b0;
         r_err      <= 1'b0;
         r_blank    <= 1'b1;
      end else begin
         r_sync1 <= seg;
         r_sync2 <= r_sync1;
         r_dv    <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            IDLE: begin
               if (r_sync2 != r_last_pat) begin
                  r_cand  <= r_sync2;
                  r_cnt   <= 8'd1;
                  r_state <= SETTLE;
               end
            end
            SETTLE: begin
               if (r_sync2 == r_cand) begin
                  if (r_cnt == CNT_LAST) begin
                     // Outputs land together with entry into REPORT.
                     r_state    <= REPORT;
                     r_cnt      <= 8'd0;
                     r_last_pat <= r_cand;
                     if (r_cand == PAT_BLANK) begin
                        r_blank <= 1'b1;
                     end else if (w_hit) begin
                        r_digit <= w_val;
                        r_dv    <= 1'b1;
                        r_blank <= 1'b0;
                     end else begin
                        r_err   <= 1'b1;
                        r_blank <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                  end
               end else if (r_sync2 == r_last_pat) begin
                  r_state <= IDLE;
                  r_cnt   <= 8'd0;
               end else begin
                  r_cand <= r_sync2;
                  r_cnt  <= 8'd1;
               end
            end
            REPORT:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign digit       = r_digit;
   assign digit_valid = r_dv;
   assign pat_err     = r_err;
   assign blank       = r_blank;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: reset, digit decode, glitch rejection,
// error/blank patterns, and reset during settling for two STABLE_CYCLES values.
module tb_seg7_capture;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_BAD   = 7'b1111110;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] seg = SEG_BLANK;
   logic [3:0] digit, digit2;
   logic       digit_valid, pat_err, blank;
   logic       digit_valid2, pat_err2, blank2;

   int checks = 0;
   int errors = 0;

   seg7_capture #(.STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg(seg),
      .digit(digit), .digit_valid(digit_valid), .pat_err(pat_err), .blank(blank)
   );

   seg7_capture #(.STABLE_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .seg(seg),
      .digit(digit2), .digit_valid(digit_valid2), .pat_err(pat_err2), .blank(blank2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, " dv"}, 8'(digit_valid), 8'd0);
         chk({tag, " err"}, 8'(pat_err), 8'd0);
      end
   endtask

   // Seg was changed just after a posedge; expect the pulse only after edge n.
   task automatic run_event(input string tag, input int n, input logic exp_dv, input logic exp_err);
      for (int i = 1; i <= n + 1; i++) begin
         tick();
         chk({tag, " dv"}, 8'(digit_valid), 8'((i == n) ? exp_dv : 1'b0));
         chk({tag, " err"}, 8'(pat_err), 8'((i == n) ? exp_err : 1'b0));
      end
   endtask

   initial begin
      // 1. asynchronous reset, mid-cycle
      #2 rst = 1'b1;
      #1;
      chk("rst digit", 8'(digit), 8'd0);
      chk("rst dv", 8'(digit_valid), 8'd0);
      chk("rst err", 8'(pat_err), 8'd0);
      chk("rst blank", 8'(blank), 8'd1);
      tick();
      tick();
      rst = 1'b0;
      quiet("idle blank", 20);
      chk("idle blank lvl", 8'(blank), 8'd1);

      // 2. digit 5, hold, then digit 7
      seg = SEG_5;
      run_event("d5", 6, 1'b1, 1'b0);
      chk("d5 digit", 8'(digit), 8'h5);
      chk("d5 blank", 8'(blank), 8'd0);
      quiet("d5 hold", 20);
      seg = SEG_7;
      run_event("d7", 6, 1'b1, 1'b0);
      chk("d7 digit", 8'(digit), 8'h7);

      // 3. glitch rejection from accepted 5
      seg = SEG_5;
      run_event("d5b", 6, 1'b1, 1'b0);
      seg = SEG_7;
      quiet("glitch", 3);
      seg = SEG_5;
      quiet("glitch back", 10);
      chk("glitch digit", 8'(digit), 8'h5);
      for (int k = 0; k < 20; k++) begin
         seg = k[0] ? SEG_0 : SEG_7;
         quiet("toggle", 2);
      end
      seg = SEG_5;
      quiet("toggle end", 10);
      chk("toggle digit", 8'(digit), 8'h5);

      // 4. unrecognised pattern
      seg = SEG_BAD;
      run_event("err", 6, 1'b0, 1'b1);
      chk("err digit", 8'(digit), 8'h5);
      chk("err blank", 8'(blank), 8'd0);

      // 5. blank, then 5 again
      seg = SEG_5;
      run_event("d5c", 6, 1'b1, 1'b0);
      seg = SEG_BLANK;
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("blank lvl", 8'(blank), 8'((i >= 6) ? 1 : 0));
         chk("blank dv", 8'(digit_valid), 8'd0);
         chk("blank err", 8'(pat_err), 8'd0);
      end
      chk("blank digit", 8'(digit), 8'h5);
      seg = SEG_5;
      run_event("d5d", 6, 1'b1, 1'b0);
      chk("d5d digit", 8'(digit), 8'h5);
      chk("d5d blank", 8'(blank), 8'd0);

      // 6. reset while settling, both STABLE_CYCLES settings
      seg = SEG_BLANK;
      quiet("pre6", 8);
      seg = SEG_5;
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rst6 digit", 8'(digit), 8'd0);
      chk("rst6 blank", 8'(blank), 8'd1);
      chk("rst6 dv2", 8'(digit_valid2), 8'd0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("rst6 dv", 8'(digit_valid), 8'((i == 6) ? 1 : 0));
         chk("rst6 dv2 pulse", 8'(digit_valid2), 8'((i == 4) ? 1 : 0));
      end
      chk("rst6 digit5", 8'(digit), 8'h5);
      chk("rst6 digit2", 8'(digit2), 8'h5);
      chk("rst6 blank2", 8'(blank2), 8'd0);
      chk("rst6 err2", 8'(pat_err2), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
